// File: rtl/load_writeback.sv
// RV32I writeback stage: drives the register-file write port and the operand bypass,
// stalls the pipeline while a load waits for data memory, and flags load timeouts.
module load_writeback #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned SYS_REGS_WIDTH = 5,
  parameter int unsigned LOAD_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_in,
  input  logic                      ex_is_load_in,
  input  logic [SYS_REGS_WIDTH-1:0] ex_rd_addr_in,
  input  logic [XLEN-1:0]           ex_result_in,
  input  logic [2:0]                ex_funct3_in,
  input  logic [1:0]                ex_addr_lsb_in,
  input  logic                      mem_rvalid_in,
  input  logic [XLEN-1:0]           mem_rdata_in,
  output logic                      halt,
  output logic                      rf_we_out,
  output logic [SYS_REGS_WIDTH-1:0] rf_waddr_out,
  output logic [XLEN-1:0]           rf_wdata_out,
  output logic [SYS_REGS_WIDTH-1:0] bypass_rd_addr,
  output logic [XLEN-1:0]           bypass_rd_data,
  output logic                      load_err_out
);

  localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          wait_cnt;
  logic [SYS_REGS_WIDTH-1:0] ld_rd;
  logic [2:0]                ld_funct3;
  logic [1:0]                ld_lsb;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic [XLEN-1:0]           load_data;
  logic                      timeout;

  // The last wait cycle is the one where the counter would reach LOAD_TIMEOUT.
  assign timeout = (wait_cnt == CNT_W'(LOAD_TIMEOUT - 1));

  // Size/sign extraction of the returned word for the latched load.
  always_comb begin
    byte_sel  = 8'(mem_rdata_in >> {ld_lsb, 3'b000});
    half_sel  = 16'(mem_rdata_in >> {ld_lsb[1], 4'b0000});
    load_data = mem_rdata_in;
    case (ld_funct3)
      3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = mem_rdata_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      ld_rd        <= '0;
      ld_funct3    <= '0;
      ld_lsb       <= '0;
      halt         <= 1'b0;
      rf_we_out    <= 1'b0;
      rf_waddr_out <= '0;
      rf_wdata_out <= '0;
      load_err_out <= 1'b0;
    end else begin
      rf_we_out <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid_in) begin
            if (ex_is_load_in) begin
              ld_rd     <= ex_rd_addr_in;
              ld_funct3 <= ex_funct3_in;
              ld_lsb    <= ex_addr_lsb_in;
              wait_cnt  <= '0;
              halt      <= 1'b1;
              state     <= LOAD_WAIT;
            end else begin
              rf_we_out    <= (ex_rd_addr_in != '0);
              rf_waddr_out <= ex_rd_addr_in;
              rf_wdata_out <= ex_result_in;
            end
          end
        end
        LOAD_WAIT: begin
          // Returning data takes priority over a coincident timeout.
          if (mem_rvalid_in) begin
            rf_we_out    <= (ld_rd != '0);
            rf_waddr_out <= ld_rd;
            rf_wdata_out <= load_data;
            halt         <= 1'b0;
            state        <= IDLE;
          end else if (timeout) begin
            rf_we_out    <= (ld_rd != '0);
            rf_waddr_out <= ld_rd;
            rf_wdata_out <= '0;
            load_err_out <= 1'b1;
            halt         <= 1'b0;
            state        <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bypass_rd_addr = rf_we_out ? rf_waddr_out : '0;
  assign bypass_rd_data = rf_we_out ? rf_wdata_out : '0;

endmodule

// File: tb/tb_load_writeback.sv
// Scoreboard bench for load_writeback: expected writes are queued at stimulus time
// (with their due cycle) and matched against the register-file port.
module tb_load_writeback;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_in, ex_is_load_in, mem_rvalid_in;
  logic [4:0]  ex_rd_addr_in;
  logic [31:0] ex_result_in, mem_rdata_in;
  logic [2:0]  ex_funct3_in;
  logic [1:0]  ex_addr_lsb_in;
  logic        halt, rf_we_out, load_err_out;
  logic [4:0]  rf_waddr_out, bypass_rd_addr;
  logic [31:0] rf_wdata_out, bypass_rd_data;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  localparam logic [31:0] RDATA = 32'h80FF7F01;

  load_writeback #(.XLEN(32), .SYS_REGS_WIDTH(5), .LOAD_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_in(ex_valid_in), .ex_is_load_in(ex_is_load_in),
    .ex_rd_addr_in(ex_rd_addr_in), .ex_result_in(ex_result_in),
    .ex_funct3_in(ex_funct3_in), .ex_addr_lsb_in(ex_addr_lsb_in),
    .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
    .halt(halt), .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out),
    .rf_wdata_out(rf_wdata_out), .bypass_rd_addr(bypass_rd_addr),
    .bypass_rd_data(bypass_rd_data), .load_err_out(load_err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_we_out) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("waddr", 64'(rf_waddr_out), 64'(e.rd));
          check("wdata", 64'(rf_wdata_out), 64'(e.data));
          check("wcycle", 64'(cyc), 64'(e.cyc));
          check("byp_addr", 64'(bypass_rd_addr), 64'(e.rd));
          check("byp_data", 64'(bypass_rd_data), 64'(e.data));
        end
      end else begin
        check("byp_idle", {27'd0, bypass_rd_addr, bypass_rd_data}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_in = 1'b0; ex_is_load_in = 1'b0; ex_rd_addr_in = '0;
    ex_result_in = '0; ex_funct3_in = '0; ex_addr_lsb_in = '0;
    mem_rvalid_in = 1'b0; mem_rdata_in = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    ex_valid_in = 1'b1; ex_is_load_in = 1'b0; ex_rd_addr_in = rd; ex_result_in = res;
    if (rd != 0) sb.push_back('{rd, res, cyc + 1});
    step();
  endtask

  // Load with `waits` empty wait cycles before rvalid; junk ex_* traffic during the wait.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb,
                         input int waits, input logic [31:0] exp);
    ex_valid_in = 1'b1; ex_is_load_in = 1'b1; ex_rd_addr_in = rd;
    ex_funct3_in = f3; ex_addr_lsb_in = lsb;
    step();
    ex_is_load_in = 1'b0; ex_rd_addr_in = 5'd3; ex_result_in = 32'hDEAD_BEEF;
    ex_funct3_in = 3'b000; ex_addr_lsb_in = 2'd0;
    for (int k = 0; k < waits; k++) begin
      check("halt_wait", 64'(halt), 64'd1);
      step();
    end
    check("halt_rv", 64'(halt), 64'd1);
    mem_rvalid_in = 1'b1; mem_rdata_in = RDATA;
    if (rd != 0) sb.push_back('{rd, exp, cyc + 1});
    step();
    idle_inputs();
    check("halt_done", 64'(halt), 64'd0);
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_we", 64'(rf_we_out), 64'd0);
    check("rst_err", 64'(load_err_out), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Back-to-back ALU results, including a suppressed rd=0 write.
    alu(5'd5, 32'h11);
    alu(5'd6, 32'h22);
    alu(5'd0, 32'h33);
    idle_inputs();
    mem_rvalid_in = 1'b1; mem_rdata_in = RDATA;
    step();
    idle_inputs();
    step();

    // Load size/sign variants.
    do_load(5'd1, 3'b000, 2'd3, 0, 32'hFFFFFF80);
    do_load(5'd2, 3'b100, 2'd3, 0, 32'h00000080);
    do_load(5'd3, 3'b001, 2'd2, 1, 32'hFFFF80FF);
    do_load(5'd4, 3'b101, 2'd1, 0, 32'h00007F01);
    do_load(5'd8, 3'b010, 2'd0, 0, 32'h80FF7F01);
    do_load(5'd0, 3'b010, 2'd0, 2, 32'h0);
    // Stall with junk ex traffic; then rvalid on the last permitted wait cycle.
    do_load(5'd7, 3'b010, 2'd0, 4, 32'h80FF7F01);
    do_load(5'd11, 3'b010, 2'd0, T - 1, 32'h80FF7F01);
    check("err_clear", 64'(load_err_out), 64'd0);

    // Timeout: zero-write and sticky error at N+T+1.
    ex_valid_in = 1'b1; ex_is_load_in = 1'b1; ex_rd_addr_in = 5'd9; ex_funct3_in = 3'b010;
    sb.push_back('{5'd9, 32'h0, cyc + int'(T) + 1});
    step();
    idle_inputs();
    for (int k = 0; k < int'(T); k++) begin
      check("to_halt", 64'(halt), 64'd1);
      check("to_err_low", 64'(load_err_out), 64'd0);
      step();
    end
    check("to_halt_end", 64'(halt), 64'd0);
    check("to_err_set", 64'(load_err_out), 64'd1);
    step(); step();
    check("to_err_sticky", 64'(load_err_out), 64'd1);

    // Reset during a pending load drops it.
    ex_valid_in = 1'b1; ex_is_load_in = 1'b1; ex_rd_addr_in = 5'd10;
    step();
    idle_inputs();
    step();
    check("pre_rst_halt", 64'(halt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_halt", 64'(halt), 64'd0);
    check("mid_rst_we", 64'(rf_we_out), 64'd0);
    check("mid_rst_err", 64'(load_err_out), 64'd0);
    step();
    rst_n = 1'b1;
    mem_rvalid_in = 1'b1; mem_rdata_in = RDATA;
    step(); step(); step();
    idle_inputs();
    check("post_rst_halt", 64'(halt), 64'd0);
    step(); step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/load_writeback.md
# load_writeback

Writeback stage of the RV32I pipeline: it takes retired results from the execute/memory stage and drives the register-file write port. It also produces the `bypass_rd_addr`/`bypass_rd_data` pair consumed by operand fetch. Loads are held in a wait state until data memory returns read data; during that wait, `halt` is asserted back to the front of the pipeline. Load data is byte/halfword extracted and sign/zero extended here, and a bounded wait timeout is reported on a sticky error flag.

## Interface
- `XLEN`, 32, datapath width
- `SYS_REGS_WIDTH`, 5, register address width
- `LOAD_TIMEOUT`, 255, maximum cycles waiting for `mem_rvalid_in` before the load is abandoned
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ex_valid_in`  in  1  a retiring instruction is presented this cycle
- `ex_is_load_in`  in  1  the presented instruction is a load
- `ex_rd_addr_in`  in  SYS_REGS_WIDTH  destination register
- `ex_result_in`  in  XLEN  ALU/CSR/link result (non-load)
- `ex_funct3_in`  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `ex_addr_lsb_in`  in  2  load address bits [1:0]
- `mem_rvalid_in`  in  1  data memory read data valid
- `mem_rdata_in`  in  XLEN  data memory read word (word aligned)
- `halt`  out  1  pipeline stall, high while a load is outstanding
- `rf_we_out`  out  1  register-file write enable, one-cycle pulse
- `rf_waddr_out`  out  SYS_REGS_WIDTH  write address
- `rf_wdata_out`  out  XLEN  write data
- `bypass_rd_addr`  out  SYS_REGS_WIDTH  forwarding address; 0 when no write
- `bypass_rd_data`  out  XLEN  forwarding data; 0 when `bypass_rd_addr` is 0
- `load_err_out`  out  1  sticky: a load timed out

## Operation
- FSM has two states, IDLE and LOAD_WAIT. Reset state is IDLE.
- IDLE, `ex_valid_in`=1, non-load: on the next edge, register `rf_we_out`=(rd≠0), `rf_waddr_out`=rd, `rf_wdata_out`=`ex_result_in`. Stay in IDLE.
- IDLE, `ex_valid_in`=1, load: latch rd, funct3 and lsb, clear the wait counter, and go to LOAD_WAIT. `rf_we_out` stays 0.
- In LOAD_WAIT, `halt`=1 and all `ex_*` inputs are ignored.
- LOAD_WAIT with `mem_rvalid_in`=1: extract data and write it on the next edge, then return to IDLE.
  - LB/LBU select byte `lsb`, with sign/zero extension respectively.
  - LH/LHU select halfword `lsb[1]`; `lsb[0]` is ignored.
  - LW and any other funct3 code take the full word.
- The wait counter increments every LOAD_WAIT cycle without `rvalid`. When it reaches `LOAD_TIMEOUT`:
  - set `load_err_out`;
  - write 32'h0 to rd (if rd≠0);
  - return to IDLE.
- If `rvalid` and timeout occur on the same cycle, `rvalid` wins and no error is recorded.
- `mem_rvalid_in` is ignored in IDLE.
- rd=0: writes are suppressed, but a load still waits for its data, with `halt` asserted as normal.
- Bypass outputs: `bypass_rd_addr` = `rf_we_out` ? `rf_waddr_out` : 0, and `bypass_rd_data` = `rf_we_out` ? `rf_wdata_out` : 0. Both are combinational from registers.
- `load_err_out` clears only on reset.

## Timing
- Reset (async assert, clean deassert): all outputs are 0 and the FSM is in IDLE. A pending load is dropped with no write.
- Non-load latency: `ex_valid_in` in cycle N gives `rf_we_out` in cycle N+1. Back-to-back instructions give back-to-back pulses.
- Load: accepted in N; `halt`=1 from N+1.
- `mem_rvalid_in` sampled high in cycle M gives `rf_we_out`=1 and `halt`=0 in M+1. The earliest M is N+1, for a total latency of 2 cycles.
- Timeout: with `LOAD_TIMEOUT`=T, a load accepted in N and never answered gives the 0-write, `load_err_out`=1 and `halt`=0 in cycle N+T+1.
- `rf_we_out` is never high for more than one cycle per retired instruction.

## Test plan
- Reset: assert `rst_n`=0 mid-LOAD_WAIT -> `halt`, `rf_we_out` and `load_err_out` are 0 immediately. No write occurs after release, even if `rvalid` arrives.
- ALU stream: `ex_valid_in` with rd=5/6/0, results 0x11/0x22/0x33, in consecutive cycles -> writes x5=0x11 and x6=0x22 in consecutive cycles. The rd=0 cycle has `rf_we_out`=0 and bypass addr/data both 0.
- Load sizes: `mem_rdata_in`=0x80FF7F01 gives the following results.
  - LB lsb=3 -> 0xFFFFFF80
  - LBU lsb=3 -> 0x00000080
  - LH lsb=2 -> 0xFFFF80FF
  - LHU lsb=1 -> 0x00007F01
  - LW -> 0x80FF7F01
- Stall: LW to x7, `rvalid` after 4 cycles -> `halt` high for exactly those cycles. Concurrent `ex_valid_in` is ignored. `bypass_rd_addr`=7 appears for one cycle.
- Timeout: `LOAD_TIMEOUT`=8, no `rvalid` -> x9 is written 0 at cycle N+9 and `load_err_out` stays 1. `rvalid` arriving on the 8th wait cycle gives a normal write and no error.
